// File: rtl/midi_note_tx.sv
// midi_note_tx -- serial MIDI note-on/note-off transmitter.
//
// Accepts one note request per valid/ready handshake and serialises it as
// 8N1 MIDI byte frames (start 0, 8 data bits LSB first, stop 1) at
// CLKS_PER_BIT clocks per bit. With RUNNING_STATUS=1 the status byte is
// dropped when it matches the previously transmitted status byte.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (FSM idle)
//   note_on    1 = note-on (0x9n), 0 = note-off (0x8n)
//   channel    MIDI channel 0..15
//   note       note number 0..127
//   velocity   velocity 0..127, sent unmodified
//   midi_tx    serial line, idle high
//   busy       message in progress (= ~req_ready)
//   msg_done   one-cycle pulse after the final stop bit of a message
module midi_note_tx #(
  parameter int CLKS_PER_BIT   = 1600,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       midi_tx,
  output logic       busy,
  output logic       msg_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;   // byte currently on the line
  logic [7:0]    r_b1;      // next byte
  logic [7:0]    r_b2;      // byte after that
  logic [1:0]    r_left;    // bytes still queued after the current one
  logic [7:0]    r_last;
  logic          r_last_vld;
  logic          r_done;

  logic       w_tick;
  logic       w_accept;
  logic       w_rs;
  logic       w_done;
  logic [7:0] w_status;

  assign w_tick   = (r_baud == BAUD_MAX);
  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_status = {1'b1, 2'b00, note_on, channel};
  // Status byte suppressed only when it repeats the last one actually sent.
  assign w_rs     = (RUNNING_STATUS != 0) && r_last_vld && (r_last == w_status);
  assign w_done   = (r_state == S_STOP) && w_tick && (r_left == 2'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA:  if (w_tick && r_bitcnt == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_tick) w_next = (r_left != 2'd0) ? S_START : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Baud counter: held at 0 while idle so the start bit gets a full bit time.
  always_ff @(posedge clk) begin
    if (!rst_n)                r_baud <= '0;
    else if (r_state == S_IDLE) r_baud <= '0;
    else if (w_tick)           r_baud <= '0;
    else                       r_baud <= r_baud + 1'b1;
  end

  // Message datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_left     <= '0;
      r_bitcnt   <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bitcnt <= '0;
            r_b2     <= {1'b0, velocity};
            if (w_rs) begin
              r_shift <= {1'b0, note};
              r_b1    <= {1'b0, velocity};
              r_left  <= 2'd1;
            end else begin
              r_shift    <= w_status;
              r_b1       <= {1'b0, note};
              r_left     <= 2'd2;
              r_last     <= w_status;
              r_last_vld <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;   // wraps to 0 after bit 7
          end
        end
        S_STOP: begin
          if (w_tick && r_left != 2'd0) begin
            r_shift <= r_b1;
            r_b1    <= r_b2;
            r_left  <= r_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    midi_tx = 1'b1;
    unique case (r_state)
      S_START: midi_tx = 1'b0;
      S_DATA:  midi_tx = r_shift[0];
      default: midi_tx = 1'b1;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;
  assign msg_done  = r_done;

endmodule
